// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem two-port arbiter.
package dmem_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam logic [3:0] WE_NONE = 4'b0000;

    typedef struct packed {
        logic              owner;
        logic              bubble;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        we;
    } issue_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Grant logic and tie-break policy state for dmem_arbiter.
// DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority with aging.
module dmem_arb_sel
    import dmem_arb_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
    parameter int MAX_WAIT = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic p0_req,
    input  logic p1_req,
    output logic p0_gnt,
    output logic p1_gnt
);

    logic p1_pref;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;

    assign p1_pref = (ptr_q == PORT_AUX);

    always_comb begin
        ptr_d = ptr_q;
        if (p0_gnt) begin
            ptr_d = PORT_AUX;
        end else if (p1_gnt) begin
            ptr_d = PORT_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PORT_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic [3:0] wait_q, wait_d;

    assign p1_pref = (wait_q >= 4'(MAX_WAIT));

    // Saturating refusal count; it can never reach 15 in practice but must not wrap.
    always_comb begin
        wait_d = wait_q;
        if (p1_gnt) begin
            wait_d = 4'd0;
        end else if (p1_req && (wait_q != 4'd15)) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= 4'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign p1_gnt = rst & p1_req & (~p0_req | p1_pref);
    assign p0_gnt = rst & p0_req & ~p1_gnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter with registered issue and response stages in front of dmem.
// DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority with aging.
module dmem_arbiter
    import dmem_arb_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
    parameter int MAX_WAIT = 4
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic [DATA_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [3:0]        p0_we,
    input  logic [3:0]        p1_we,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [DATA_W-1:0] daddr,
    output logic [DATA_W-1:0] dwdata,
    output logic [3:0]        we,
    input  logic [DATA_W-1:0] drdata
);

`ifdef DMEM_ARB_RR_EN
    dmem_arb_sel u_sel (
`else
    dmem_arb_sel #(.MAX_WAIT(MAX_WAIT)) u_sel (
`endif
        .clk    (clk),
        .rst    (rst),
        .p0_req (p0_req),
        .p1_req (p1_req),
        .p0_gnt (p0_gnt),
        .p1_gnt (p1_gnt)
    );

    // Issue stage: winner captured at the end of the grant cycle, drives dmem.
    issue_t iss_q, iss_d;

    always_comb begin
        iss_d        = iss_q;
        iss_d.bubble = 1'b1;
        iss_d.we     = WE_NONE;
        if (p0_gnt) begin
            iss_d.owner  = PORT_CPU;
            iss_d.bubble = 1'b0;
            iss_d.addr   = p0_addr;
            iss_d.wdata  = p0_wdata;
            iss_d.we     = p0_we;
        end else if (p1_gnt) begin
            iss_d.owner  = PORT_AUX;
            iss_d.bubble = 1'b0;
            iss_d.addr   = p1_addr;
            iss_d.wdata  = p1_wdata;
            iss_d.we     = p1_we;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_q <= '{owner: PORT_CPU, bubble: 1'b1, addr: '0, wdata: '0, we: WE_NONE};
        end else begin
            iss_q <= iss_d;
        end
    end

    assign daddr  = iss_q.addr;
    assign dwdata = iss_q.wdata;
    assign we     = iss_q.we;

    // Response stage: drdata of the access cycle returned to its owner.
    logic              rsp_vld_q;
    logic              rsp_own_q;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    always_comb begin
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        if (!iss_q.bubble) begin
            if (iss_q.owner == PORT_CPU) begin
                p0_rdata_d = drdata;
            end else begin
                p1_rdata_d = drdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld_q  <= 1'b0;
            rsp_own_q  <= PORT_CPU;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            rsp_vld_q  <= ~iss_q.bubble;
            rsp_own_q  <= iss_q.owner;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign p0_rvalid = rsp_vld_q & (rsp_own_q == PORT_CPU);
    assign p1_rvalid = rsp_vld_q & (rsp_own_q == PORT_AUX);
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule
